// File: rtl/waveform_sample_packer_if.sv
// Serial per-channel sample stream feeding the packer: one channel per beat,
// with the first-beat marker qualifying channel 0 of each frame.
interface waveform_sample_packer_if #(
  parameter int SAMPLE_WIDTH = 32
);
  logic [SAMPLE_WIDTH-1:0] sampleData;
  logic                    sampleValid;
  logic                    sampleFirst;

  // Producer side (ADC front end or bench)
  modport master (
    output sampleData,
    output sampleValid,
    output sampleFirst
  );

  // Consumer side (the packer)
  modport slave (
    input sampleData,
    input sampleValid,
    input sampleFirst
  );
endinterface

// File: rtl/waveform_sample_packer.sv
// waveform_sample_packer
// Gathers serially delivered channel samples into one wide word per frame,
// decimates completed frames by a runtime factor and presents data, a one-cycle
// valid strobe, accumulated triggers and the lane-0 timestamp to the recorder.
module waveform_sample_packer #(
  parameter int SAMPLE_WIDTH    = 32,
  parameter int CHANNELS        = 4,
  parameter int DATA_WIDTH      = 128,
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int DECIM_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       enable,
  input  logic [DECIM_WIDTH-1:0]     decimateFactor,
  waveform_sample_packer_if.slave    sample,
  input  logic [7:0]                 triggersIn,
  input  logic [TIMESTAMP_WIDTH-1:0] timestampIn,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       valid,
  output logic [7:0]                 triggers,
  output logic [TIMESTAMP_WIDTH-1:0] timestamp,
  output logic [15:0]                framingErrors
);

  // Channel index width; a single-channel build still needs a 1-bit index.
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CHANNELS - 1);
  // Only lanes 0..CHANNELS-2 need storage: the last lane comes straight from
  // the completing beat.
  localparam int HELD = (CHANNELS > 1) ? CHANNELS - 1 : 1;

  if (DATA_WIDTH != SAMPLE_WIDTH * CHANNELS) begin : g_width_check
    $error("waveform_sample_packer: DATA_WIDTH must equal SAMPLE_WIDTH*CHANNELS");
  end
  if (CHANNELS < 1) begin : g_channel_check
    $error("waveform_sample_packer: CHANNELS must be at least 1");
  end

  typedef enum logic {
    S_SYNC = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Frame assembly state
  state_t                     state_reg;
  state_t                     state_next;
  logic [CH_W-1:0]            ch_idx_reg;
  logic [CH_W-1:0]            ch_idx_next;
  logic                       locked_reg;
  logic [SAMPLE_WIDTH-1:0]    lanes_reg [HELD];
  logic [TIMESTAMP_WIDTH-1:0] ts_latch_reg;

  // Decimation, trigger accumulation and error counting
  logic [DECIM_WIDTH-1:0]     decim_count_reg;
  logic [DECIM_WIDTH-1:0]     decim_reload;
  logic [7:0]                 trig_acc_reg;
  logic [7:0]                 trig_all;
  logic [15:0]                err_count_reg;

  // Per-cycle decisions from the framing FSM
  logic                       store_en;
  logic [CH_W-1:0]            store_idx;
  logic                       ts_load;
  logic                       frame_done;
  logic                       err_inc;
  logic                       lock_set;
  logic                       emit;

  // Completed-frame view presented to the output register
  logic [DATA_WIDTH-1:0]      frame_word;
  logic [TIMESTAMP_WIDTH-1:0] frame_ts;

  assign framingErrors = err_count_reg;

  // Framing FSM: decide what the current beat does to the frame in progress.
  always_comb begin
    state_next  = state_reg;
    ch_idx_next = ch_idx_reg;
    store_en    = 1'b0;
    store_idx   = '0;
    ts_load     = 1'b0;
    frame_done  = 1'b0;
    err_inc     = 1'b0;
    lock_set    = 1'b0;
    case (state_reg)
      S_SYNC: begin
        if (sample.sampleValid) begin
          if (sample.sampleFirst) begin
            store_en = 1'b1;
            ts_load  = 1'b1;
            lock_set = 1'b1;
            if (CHANNELS == 1) begin
              // A lone channel is a complete frame on its own.
              frame_done = 1'b1;
            end else begin
              ch_idx_next = CH_W'(1);
              state_next  = S_FILL;
            end
          end else if (locked_reg) begin
            // Stray beats only count as errors once we have seen framing.
            err_inc = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (sample.sampleValid) begin
          if (sample.sampleFirst) begin
            // Premature frame start: drop the partial frame, restart at lane 0.
            err_inc     = 1'b1;
            store_en    = 1'b1;
            ts_load     = 1'b1;
            ch_idx_next = CH_W'(1);
          end else begin
            store_en  = 1'b1;
            store_idx = ch_idx_reg;
            if (ch_idx_reg == LAST_IDX) begin
              frame_done  = 1'b1;
              ch_idx_next = '0;
              state_next  = S_SYNC;
            end else begin
              ch_idx_next = ch_idx_reg + CH_W'(1);
            end
          end
        end
      end
      default: begin
        state_next  = S_SYNC;
        ch_idx_next = '0;
      end
    endcase
  end

  // Framing state register; enable low restarts framing but keeps the lock.
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      state_reg  <= S_SYNC;
      ch_idx_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ch_idx_reg <= ch_idx_next;
    end
  end

  // Lock flag: set by the first properly marked beat, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      locked_reg <= 1'b0;
    end else if (enable && lock_set) begin
      locked_reg <= 1'b1;
    end
  end

  // Lane storage and word assembly; the last lane bypasses storage.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    if (gi == CHANNELS - 1) begin : g_last
      assign frame_word[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample.sampleData;
    end else begin : g_held
      // Capture this lane's sample when its beat arrives.
      always_ff @(posedge clk) begin
        if (store_en && (store_idx == CH_W'(gi))) begin
          lanes_reg[gi] <= sample.sampleData;
        end
      end
      assign frame_word[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lanes_reg[gi];
    end
  end

  // Lane-0 timestamp latch, kept apart from the presented timestamp.
  always_ff @(posedge clk) begin
    if (ts_load) begin
      ts_latch_reg <= timestampIn;
    end
  end

  // Single-channel frames complete on their lane-0 beat, so use the live value.
  assign frame_ts = (CHANNELS == 1) ? timestampIn : ts_latch_reg;

  // Decimation: emit when the countdown is at zero, then reload from the factor.
  assign decim_reload = (decimateFactor == '0) ? '0 : decimateFactor - DECIM_WIDTH'(1);
  assign emit         = frame_done && (decim_count_reg == '0);

  // Decimation countdown, advanced once per completed frame.
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      decim_count_reg <= '0;
    end else if (frame_done) begin
      if (decim_count_reg == '0) begin
        decim_count_reg <= decim_reload;
      end else begin
        decim_count_reg <= decim_count_reg - DECIM_WIDTH'(1);
      end
    end
  end

  // Triggers seen over the interval, including the emitting cycle itself.
  assign trig_all = trig_acc_reg | triggersIn;

  // Trigger accumulator: restarts after each emitted frame.
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      trig_acc_reg <= '0;
    end else if (emit) begin
      trig_acc_reg <= '0;
    end else begin
      trig_acc_reg <= trig_all;
    end
  end

  // Saturating framing-error counter, survives enable low.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      err_count_reg <= '0;
    end else if (enable && err_inc && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  // Output register: one-cycle strobe; data and timestamp hold between emits.
  always_ff @(posedge clk) begin
    if (!resetN || !enable) begin
      data      <= '0;
      valid     <= 1'b0;
      triggers  <= '0;
      timestamp <= '0;
    end else begin
      valid <= emit;
      if (emit) begin
        data      <= frame_word;
        timestamp <= frame_ts;
        triggers  <= trig_all;
      end else begin
        triggers  <= '0;
      end
    end
  end

endmodule
